// File: rtl/stack_seq.sv
// Request sequencer in front of the 32x32 hardware stack: turns accepted
// push/pop requests into isolated one-cycle strobes and tracks occupancy.
module stack_seq #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 31,
   parameter int CNT_W  = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic              req_push,
   input  logic [DATA_W-1:0] req_data,
   output logic              req_ready,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_data,
   output logic [CNT_W-1:0]  depth,
   output logic              full,
   output logic              empty,
   output logic              err_overflow,
   output logic              err_underflow,
   input  logic              err_clr,
   output logic              stk_write,
   output logic              stk_read,
   output logic [DATA_W-1:0] stk_din,
   input  logic [DATA_W-1:0] stk_dout
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] STROBE  = 2'd1;
   localparam logic [1:0] RELEASE = 2'd2;

   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [1:0]        r_state;
   logic              r_write;
   logic              r_read;
   logic [DATA_W-1:0] r_din;
   logic              r_respValid;
   logic [DATA_W-1:0] r_respData;
   logic [CNT_W-1:0]  r_depth;
   logic              r_errOv;
   logic              r_errUn;

   logic w_accept;
   logic w_full;
   logic w_empty;
   logic w_pushOk;
   logic w_popOk;
   logic w_setOv;
   logic w_setUn;

   assign w_full   = (r_depth == FULL_CNT);
   assign w_empty  = (r_depth == '0);
   assign w_accept = req_valid && (r_state == IDLE);
   assign w_pushOk = w_accept &&  req_push && !w_full;
   assign w_popOk  = w_accept && !req_push && !w_empty;
   assign w_setOv  = w_accept &&  req_push &&  w_full;
   assign w_setUn  = w_accept && !req_push &&  w_empty;

   // Strobes only rise from IDLE, so every strobe is followed by a low cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_write <= 1'b0;
         r_read  <= 1'b0;
         r_din   <= '0;
      end else begin
         case (r_state)
            IDLE:    if (w_pushOk || w_popOk) r_state <= STROBE;
            STROBE:  r_state <= RELEASE;
            default: r_state <= IDLE;
         endcase
         r_write <= w_pushOk;
         r_read  <= w_popOk;
         if (w_accept && req_push) r_din <= req_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_depth     <= '0;
         r_respValid <= 1'b0;
         r_respData  <= '0;
      end else begin
         if (r_write)
            r_depth <= r_depth + 1'b1;
         else if (r_read)
            r_depth <= r_depth - 1'b1;
         r_respValid <= r_read;
         if (r_read) r_respData <= stk_dout;
      end
   end

   // A fresh error in the same cycle as a clear takes priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_errOv <= 1'b0;
         r_errUn <= 1'b0;
      end else begin
         r_errOv <= w_setOv || (r_errOv && !err_clr);
         r_errUn <= w_setUn || (r_errUn && !err_clr);
      end
   end

   assign req_ready     = (r_state == IDLE);
   assign resp_valid    = r_respValid;
   assign resp_data     = r_respData;
   assign depth         = r_depth;
   assign full          = w_full;
   assign empty         = w_empty;
   assign err_overflow  = r_errOv;
   assign err_underflow = r_errUn;
   assign stk_write     = r_write;
   assign stk_read      = r_read;
   assign stk_din       = r_din;

endmodule

// File: doc/stack_seq.md
Name: stack_seq

Overview:
- Request sequencer directly upstream of the 32x32 hardware stack.
- Accepts push/pop requests from the control unit over a valid/ready handshake.
- Converts each request into a clean, single, isolated read or write strobe. The stack is level/edge-sensitive on its strobes, so every strobe must return low between operations.
- Tracks occupancy, blocks overflow/underflow, and returns popped data through a registered response.

Parameters:
- DATA_W, 32, data word width; must match the stack word width.
- DEPTH, 31, usable stack entries. The stack pointer starts at 1, so entry 0 is unused.
- CNT_W, 6, depth counter width; must satisfy 2^CNT_W > DEPTH.

Ports:
- clk  in  1  system clock; rising edge active.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_push  in  1  1 = push, 0 = pop; sampled with req_valid.
- req_data  in  DATA_W  push data; sampled on accept.
- req_ready  out  1  sequencer can accept a request this cycle.
- resp_valid  out  1  one-cycle pulse; resp_data holds popped word.
- resp_data  out  DATA_W  last popped word; holds until next pop.
- depth  out  CNT_W  current number of stored entries.
- full  out  1  depth == DEPTH.
- empty  out  1  depth == 0.
- err_overflow  out  1  sticky; push attempted while full.
- err_underflow  out  1  sticky; pop attempted while empty.
- err_clr  in  1  synchronous clear of both sticky errors.
- stk_write  out  1  write strobe to stack.
- stk_read  out  1  read strobe to stack.
- stk_din  out  DATA_W  data to stack data_in.
- stk_dout  in  DATA_W  data from stack data_out.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; stk_write=0, stk_read=0, stk_din=0.
  - resp_valid=0, resp_data=0, depth=0, both errors=0.
  - req_ready goes to 1 once rst_n deasserts.
  - rst_n is only asserted as part of a system reset that also reinitialises the stack.
  - Reset mid-operation drops both strobes immediately and discards the in-flight request; no partial depth update.
- Outputs:
  - full and empty are combinational from depth.
  - req_ready = (state==IDLE).
- Accept: rising edge with req_valid & req_ready (call it cycle N). On accept, stk_din <= req_data for a push; stk_din is unchanged for a pop.
- FSM states: IDLE, STROBE, RELEASE.
  - IDLE -> STROBE: legal accept, i.e. push with !full, or pop with !empty.
  - IDLE -> IDLE: illegal accept, i.e. push with full, or pop with empty.
    - Sets the matching sticky error at N+1.
    - No strobe, no depth change, no resp_valid.
    - req_ready stays 1.
  - STROBE (cycle N+1):
    - Exactly one of stk_write or stk_read is 1, registered and glitch-free.
    - stk_din is stable for the whole cycle.
    - At the end-of-cycle edge: depth +1 for push, -1 for pop.
    - For a pop, resp_data <= stk_dout (stack output is valid while read is high).
    - Always -> RELEASE.
  - RELEASE (cycle N+2):
    - Both strobes 0.
    - resp_valid=1 for exactly this cycle, pops only.
    - Always -> IDLE.
- Latency and throughput:
  - Pop: accept to resp_valid is 2 cycles.
  - Minimum spacing between accepted legal requests is 3 cycles.
  - stk_read and stk_write are never high together, and never high in consecutive cycles.
- req_valid while busy is ignored. The requester must hold req_valid, req_push and req_data until accepted.
- err_clr:
  - Clears both sticky errors on the next edge.
  - If a new error is set in the same cycle as err_clr, set wins.
- depth saturation is impossible by construction: it never leaves 0..DEPTH.
- resp_data is unchanged by pushes and by rejected pops.

Test Plan:
1. Reset, then push 0xDEADBEEF and 0x00000001, then pop twice:
   - Pops give resp_data 0x00000001 then 0xDEADBEEF.
   - Each resp_valid comes 2 cycles after its accept.
   - depth goes 1, 2, 1, 0; empty=1 at the end.
2. Pop on empty after reset:
   - err_underflow=1 at N+1; no stk_read pulse; depth=0; resp_data=0.
   - err_clr=1 for one cycle -> err_underflow=0.
3. Push 31 words 0x0..0x1E: full=1, depth=31.
   - 32nd push 0xFFFFFFFF -> err_overflow=1, no stk_write, depth=31.
   - Then 31 pops return 0x1E down to 0x0 in order.
4. Hold req_valid=1 continuously with alternating push/pop:
   - req_ready is high one cycle in three.
   - Strobes are one cycle wide, separated by at least one low cycle.
   - Never both high.
5. Assert rst_n=0 during STROBE of a push (depth=3):
   - stk_write drops with no clock edge; depth=0; state=IDLE.
   - req_ready=1 after release.
6. Pop on empty with err_clr=1 in the same accept cycle -> err_underflow=1 (set wins).
